// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal register with mode ops and counted burst-shift engine (n_q port under UREG_NQ_EN)
module univ_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Set,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   d,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic               start,
  input  logic [SHIFT_W-1:0] shamt,
  output logic [WIDTH-1:0]   q,
`ifdef UREG_NQ_EN
  output logic [WIDTH-1:0]   n_q,
`endif
  output logic               sout_l,
  output logic               sout_r,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_CLR   = 3'b110;
  localparam logic [2:0] M_INV   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [SHIFT_W-1:0] cnt, cnt_n;
  logic [2:0]         mode_l, mode_l_n;
  logic [WIDTH-1:0]   q_n;
  logic               start_ok;

  // One mode operation applied to a register value; shared by the single-cycle and burst paths
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] ld, input logic sl,
                                                input logic sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_HOLD: r = v;
      M_LOAD: r = ld;
      M_SHL:  r = {v[WIDTH-2:0], sr};
      M_SHR:  r = {sl, v[WIDTH-1:1]};
      M_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:  r = {v[0], v[WIDTH-1:1]};
      M_CLR:  r = '0;
      M_INV:  r = ~v;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the four shift/rotate modes may launch a burst (010..101)
  assign start_ok = start && (mode[2] ^ mode[1]);

  // Next-state, next-q and burst counter; Set overrides the engine and aborts any burst
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mode_l_n = mode_l;
    q_n      = q;
    if (Set) begin
      q_n     = '1;
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mode_l_n = mode;
            cnt_n    = shamt;
            state_n  = (shamt != '0) ? S_SHIFT : S_DONE;
          end else if (en) begin
            q_n = apply_op(mode, q, d, sin_l, sin_r);
          end
        end
        S_SHIFT: begin
          q_n   = apply_op(mode_l, q, d, sin_l, sin_r);
          cnt_n = cnt - 1'b1;
          if (cnt == SHIFT_W'(1)) state_n = S_DONE;
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_l <= M_HOLD;
      q      <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_l <= mode_l_n;
      q      <= q_n;
    end
  end

  assign busy   = (state == S_SHIFT);
  assign done   = (state == S_DONE);
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
`ifdef UREG_NQ_EN
  assign n_q    = ~q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       Reset, Set, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] shamt;
  logic [7:0] q;
`ifdef UREG_NQ_EN
  logic [7:0] n_q;
`endif
  logic       sout_l, sout_r, busy, done;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  univ_shift_reg #(.WIDTH(8), .SHIFT_W(4)) dut (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .shamt(shamt), .q(q),
`ifdef UREG_NQ_EN
    .n_q(n_q),
`endif
    .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Queue the expectation for the coming edge
  task automatic expect_q(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later and compare against the oldest expectation
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (q === e.q) passed++;
    else $error("FAIL %s q: got %h want %h", e.tag, q, e.q);
    checks++;
    assert (busy === e.busy) passed++;
    else $error("FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
    checks++;
    assert (done === e.done) passed++;
    else $error("FAIL %s done: got %b want %b", e.tag, done, e.done);
    checks++;
    assert ({sout_l, sout_r} === {e.q[7], e.q[0]}) passed++;
    else $error("FAIL %s sout: got %b%b want %b%b", e.tag, sout_l, sout_r, e.q[7], e.q[0]);
`ifdef UREG_NQ_EN
    checks++;
    assert (n_q === ~e.q) passed++;
    else $error("FAIL %s n_q: got %h want %h", e.tag, n_q, ~e.q);
`endif
  endtask

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin
    // Reset dominates Set/en/load
    Reset = 1'b0; Set = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hA5;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; shamt = 4'd0;
    expect_q("reset", 8'h00, 1'b0, 1'b0); step();
    expect_q("reset_hold", 8'h00, 1'b0, 1'b0); step();
    Reset = 1'b1;
    expect_q("set", 8'hFF, 1'b0, 1'b0); step();

    // Single-cycle modes
    Set = 1'b0; d = 8'h00;
    expect_q("load00", 8'h00, 1'b0, 1'b0); step();
    d = 8'h96;
    expect_q("load96", 8'h96, 1'b0, 1'b0); step();
    mode = 3'b100; expect_q("rol", 8'h2D, 1'b0, 1'b0); step();
    mode = 3'b101; expect_q("ror", 8'h96, 1'b0, 1'b0); step();
    mode = 3'b111; expect_q("inv", 8'h69, 1'b0, 1'b0); step();
    mode = 3'b010; sin_r = 1'b1; expect_q("shl", 8'hD3, 1'b0, 1'b0); step();
    mode = 3'b011; sin_l = 1'b0; expect_q("shr", 8'h69, 1'b0, 1'b0); step();
    mode = 3'b110; expect_q("clr", 8'h00, 1'b0, 1'b0); step();
    en = 1'b0; mode = 3'b001; d = 8'h55; expect_q("en_off", 8'h00, 1'b0, 1'b0); step();
    en = 1'b1; mode = 3'b000; expect_q("hold", 8'h00, 1'b0, 1'b0); step();
    // start with a non-shift mode falls back to the en/mode path
    start = 1'b1; mode = 3'b001; d = 8'h81; expect_q("start_load", 8'h81, 1'b0, 1'b0); step();

    // Burst SHR x3 with sin_l=1, junk on ignored inputs while shifting
    en = 1'b0; mode = 3'b011; shamt = 4'd3; sin_l = 1'b1;
    expect_q("b3_start", 8'h81, 1'b1, 1'b0); step();
    start = 1'b0; en = 1'b1; mode = 3'b001; d = 8'h00;
    expect_q("b3_s1", 8'hC0, 1'b1, 1'b0); step();
    start = 1'b1; mode = 3'b110;
    expect_q("b3_s2", 8'hE0, 1'b1, 1'b0); step();
    start = 1'b0; mode = 3'b111;
    expect_q("b3_s3", 8'hF0, 1'b0, 1'b1); step();
    // start/en in DONE are ignored
    start = 1'b1; mode = 3'b010; shamt = 4'd2;
    expect_q("b3_after", 8'hF0, 1'b0, 1'b0); step();

    // Zero-length burst
    en = 1'b0; start = 1'b1; mode = 3'b010; shamt = 4'd0;
    expect_q("z_start", 8'hF0, 1'b0, 1'b1); step();
    start = 1'b0;
    expect_q("z_after", 8'hF0, 1'b0, 1'b0); step();

    // Set aborts a long ROL burst
    en = 1'b1; mode = 3'b001; d = 8'h01;
    expect_q("ab_load", 8'h01, 1'b0, 1'b0); step();
    en = 1'b0; start = 1'b1; mode = 3'b100; shamt = 4'd10;
    expect_q("ab_start", 8'h01, 1'b1, 1'b0); step();
    start = 1'b0;
    expect_q("ab_s1", 8'h02, 1'b1, 1'b0); step();
    expect_q("ab_s2", 8'h04, 1'b1, 1'b0); step();
    Set = 1'b1;
    expect_q("ab_set", 8'hFF, 1'b0, 1'b0); step();
    Set = 1'b0;
    expect_q("ab_nodone", 8'hFF, 1'b0, 1'b0); step();

    // shamt >= WIDTH: ROL wraps, inputs scrambled every cycle
    en = 1'b1; mode = 3'b001; d = 8'h03;
    expect_q("w_load", 8'h03, 1'b0, 1'b0); step();
    en = 1'b0; start = 1'b1; mode = 3'b100; shamt = 4'd10;
    expect_q("w_start", 8'h03, 1'b1, 1'b0); step();
    for (int i = 1; i <= 10; i++) begin
      en = 1'($urandom); start = 1'($urandom); mode = 3'($urandom);
      d = 8'($urandom); shamt = 4'($urandom);
      expect_q("w_shift", rol(8'h03, i), (i < 10), (i == 10));
      step();
    end
    en = 1'b0; start = 1'b0;
    expect_q("w_final", 8'h0C, 1'b0, 1'b0); step();

    // SHL x9 fully replaces contents with sin_r
    start = 1'b1; mode = 3'b010; shamt = 4'd9; sin_r = 1'b1;
    expect_q("f_start", 8'h0C, 1'b1, 1'b0); step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      expect_q("f_shift", 8'((16'h000C << i) | ((16'h1 << i) - 1)), (i < 9), (i == 9));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
